// File: rtl/dircc_pkg.sv
// Definitions shared by the DIRCC arbiters: FSM state encoding, index-width helper
// and the requester-count ceiling.
package dircc_pkg;

   localparam int DIRCC_MAX_REQ = 16;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} dircc_state_e;

   // Width of an index into n requesters; never narrower than one bit.
   function automatic int dircc_clog2(input int n);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/dircc_rr_picker.sv
// Combinational round-robin select: first asserted request at or after i_rr_ptr,
// wrapping modulo NUM_REQ.
module dircc_rr_picker
   import dircc_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = dircc_clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_rr_ptr,
   output logic               o_any_req,
   output logic [IDX_W-1:0]   o_winner
);

   logic [NUM_REQ-1:0]   w_mask;
   logic [2*NUM_REQ-1:0] w_dbl;

   // Lower half keeps only requests at/after the pointer, upper half is the full
   // vector for the wrap; the lowest set bit of the concatenation is the winner.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         w_mask[i] = (i >= int'(i_rr_ptr));
      end
      w_dbl     = {i_req, i_req & w_mask};
      o_any_req = |i_req;
      o_winner  = '0;
      for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
         if (w_dbl[i]) o_winner = IDX_W'(i % NUM_REQ);
      end
   end

endmodule

// File: rtl/dircc_slave_read_arbiter.sv
// Round-robin arbiter sharing one read-only Avalon-MM control slave among NUM_REQ
// requesters; one read outstanding, one-cycle rvalid pulse per response.
module dircc_slave_read_arbiter
   import dircc_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int ADDR_W       = 1,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 0
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_address,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic [ADDR_W-1:0]         m_address,
   output logic                      m_read,
   input  logic [DATA_W-1:0]         m_readdata,
   input  logic                      m_waitrequest
);

   localparam int IDX_W    = dircc_clog2(NUM_REQ);
   localparam int LAT_W    = 3;
   localparam int LAT_INIT = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;

   dircc_state_e      r_state,   w_state_nxt;
   logic [IDX_W-1:0]  r_rr_ptr,  w_rr_ptr_nxt;
   logic [IDX_W-1:0]  r_gnt_idx, w_gnt_idx_nxt;
   logic [ADDR_W-1:0] r_addr_q,  w_addr_q_nxt;
   logic [DATA_W-1:0] r_data_q,  w_data_q_nxt;
   logic [LAT_W-1:0]  r_lat_cnt, w_lat_cnt_nxt;

   logic              w_any_req;
   logic [IDX_W-1:0]  w_winner;

   dircc_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .i_req     (req),
      .i_rr_ptr  (r_rr_ptr),
      .o_any_req (w_any_req),
      .o_winner  (w_winner)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_rr_ptr  <= '0;
         r_gnt_idx <= '0;
         r_addr_q  <= '0;
         r_data_q  <= '0;
         r_lat_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_rr_ptr  <= w_rr_ptr_nxt;
         r_gnt_idx <= w_gnt_idx_nxt;
         r_addr_q  <= w_addr_q_nxt;
         r_data_q  <= w_data_q_nxt;
         r_lat_cnt <= w_lat_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_rr_ptr_nxt  = r_rr_ptr;
      w_gnt_idx_nxt = r_gnt_idx;
      w_addr_q_nxt  = r_addr_q;
      w_data_q_nxt  = r_data_q;
      w_lat_cnt_nxt = r_lat_cnt;
      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               w_gnt_idx_nxt = w_winner;
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (w_winner == IDX_W'(i)) w_addr_q_nxt = req_address[i*ADDR_W +: ADDR_W];
               end
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (!m_waitrequest) begin
               if (READ_LATENCY == 0) begin
                  w_data_q_nxt = m_readdata;
                  w_state_nxt  = RESP;
               end else begin
                  w_lat_cnt_nxt = LAT_W'(LAT_INIT);
                  w_state_nxt   = WAIT;
               end
            end
         end
         WAIT: begin
            if (r_lat_cnt == '0) begin
               w_data_q_nxt = m_readdata;
               w_state_nxt  = RESP;
            end else begin
               w_lat_cnt_nxt = r_lat_cnt - LAT_W'(1);
            end
         end
         RESP: begin
            // The requester just served drops to lowest priority for the next scan.
            w_rr_ptr_nxt = (r_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + IDX_W'(1);
            w_state_nxt  = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         rvalid[i] = (r_state == RESP) && (r_gnt_idx == IDX_W'(i));
      end
   end

   assign rdata     = r_data_q;
   assign m_read    = (r_state == ISSUE);
   assign m_address = r_addr_q;

endmodule
